// File: rtl/dsa_cmd_engine.sv
// Command engine: pops 96-bit commands, runs ADD/SUB/MUL/MAC/CLR/RDACC,
// pushes one 32-bit response per command. MUL/MAC use a 32-step shift-add.
module dsa_cmd_engine (
    input  logic        dsa_clk,
    input  logic        dsa_rst,
    input  logic        cmd_empty,
    output logic        cmd_rd_en,
    input  logic [95:0] cmd_data,
    input  logic        rsp_full,
    output logic        rsp_wr_en,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic [15:0] cmd_cnt,
    output logic        err_flag
);

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, RESP} state_t;

    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_SUB   = 8'h02;
    localparam logic [7:0] OP_MUL   = 8'h03;
    localparam logic [7:0] OP_MAC   = 8'h04;
    localparam logic [7:0] OP_CLR   = 8'h05;
    localparam logic [7:0] OP_RDACC = 8'h06;

    state_t      state, next_state;
    logic [7:0]  opcode_q;
    logic [31:0] a_q, b_q, prod_q, acc_q;
    logic [4:0]  step_q;
    logic        is_mul_op, exec_done, illegal;
    logic [31:0] prod_next, result;
    logic        unused_cmd_hi;

    assign unused_cmd_hi = ^cmd_data[95:72];
    assign is_mul_op     = (opcode_q == OP_MUL) || (opcode_q == OP_MAC);
    assign busy          = (state != IDLE);

    // One shift-add step: a_q is shifted left and b_q right each EXEC cycle.
    assign prod_next = prod_q + (b_q[0] ? a_q : 32'd0);

    always_ff @(posedge dsa_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of the others.
        if (dsa_rst) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        next_state = state;
        cmd_rd_en  = 1'b0;
        rsp_wr_en  = 1'b0;
        exec_done  = 1'b0;
        case (state)
            IDLE: if (!cmd_empty) begin
                cmd_rd_en  = 1'b1;
                next_state = LOAD;
            end
            LOAD: next_state = EXEC;
            EXEC: if (!is_mul_op || step_q == 5'd31) begin
                exec_done  = 1'b1;
                next_state = RESP;
            end
            RESP: if (!rsp_full) begin
                rsp_wr_en  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // Reset may arrive in any state; no FIFO strobe may escape that cycle.
        if (dsa_rst) begin
            cmd_rd_en = 1'b0;
            rsp_wr_en = 1'b0;
        end
    end

    always_comb begin
        result  = 32'd0;
        illegal = 1'b0;
        case (opcode_q)
            OP_ADD:   result = a_q + b_q;
            OP_SUB:   result = a_q - b_q;
            OP_MUL:   result = prod_next;
            OP_MAC:   result = acc_q + prod_next;
            OP_CLR:   result = 32'd0;
            OP_RDACC: result = acc_q;
            default: begin
                result  = {24'hBAD000, opcode_q};
                illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge dsa_clk) begin
        if (dsa_rst) begin
            opcode_q <= 8'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            prod_q   <= 32'd0;
            step_q   <= 5'd0;
            acc_q    <= 32'd0;
            rsp_data <= 32'd0;
            cmd_cnt  <= 16'd0;
            err_flag <= 1'b0;
        end else begin
            if (state == LOAD) begin
                opcode_q <= cmd_data[71:64];
                a_q      <= cmd_data[63:32];
                b_q      <= cmd_data[31:0];
                prod_q   <= 32'd0;
                step_q   <= 5'd0;
            end
            if (state == EXEC && is_mul_op) begin
                prod_q <= prod_next;
                a_q    <= a_q << 1;
                b_q    <= b_q >> 1;
                step_q <= step_q + 5'd1;
            end
            // Accumulator and response commit together, before any RESP stall.
            if (exec_done) begin
                rsp_data <= result;
                if (opcode_q == OP_MAC || opcode_q == OP_CLR) acc_q <= result;
                if (illegal) err_flag <= 1'b1;
            end
            if (rsp_wr_en) cmd_cnt <= cmd_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_dsa_cmd_engine.sv
// Self-checking bench for dsa_cmd_engine: directed vector table, random commands
// against a behavioural model, reset-abort, counter wrap and empty-FIFO idling.
module tb_dsa_cmd_engine;

    logic        dsa_clk = 1'b0;
    logic        dsa_rst;
    logic        cmd_empty;
    logic        cmd_rd_en;
    logic [95:0] cmd_data;
    logic        rsp_full;
    logic        rsp_wr_en;
    logic [31:0] rsp_data;
    logic        busy;
    logic [15:0] cmd_cnt;
    logic        err_flag;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] m_acc = 32'd0;
    logic        m_err = 1'b0;
    logic [15:0] m_cnt = 16'd0;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          stall;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    dsa_cmd_engine dut (
        .dsa_clk   (dsa_clk),
        .dsa_rst   (dsa_rst),
        .cmd_empty (cmd_empty),
        .cmd_rd_en (cmd_rd_en),
        .cmd_data  (cmd_data),
        .rsp_full  (rsp_full),
        .rsp_wr_en (rsp_wr_en),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .cmd_cnt   (cmd_cnt),
        .err_flag  (err_flag)
    );

    always #5 dsa_clk = ~dsa_clk;
    always @(posedge dsa_clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge dsa_clk);
        #1;
    endtask

    // Reference model: opcode semantics with plain arithmetic.
    task automatic ref_exec(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] r);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            8'h01: r = a + b;
            8'h02: r = a - b;
            8'h03: r = p[31:0];
            8'h04: begin m_acc = m_acc + p[31:0]; r = m_acc; end
            8'h05: begin m_acc = 32'd0; r = 32'd0; end
            8'h06: r = m_acc;
            default: begin m_err = 1'b1; r = {24'hBAD000, op}; end
        endcase
    endtask

    // Offer one command, then follow it to its response write.
    task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int stall, input logic hold, input logic [31:0] exp);
        int n, wr_cyc, exp_lat, busy_bad, rd_bad, stall_bad;
        logic found, seen;
        logic [31:0] got, junk;
        exp_lat = (op == 8'h03 || op == 8'h04) ? 34 : 3;
        busy_bad = 0; rd_bad = 0; stall_bad = 0; seen = 1'b0; got = 32'd0; wr_cyc = 0;
        cmd_empty = 1'b0;
        #1;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (cmd_rd_en) begin found = 1'b1; break; end
            step(); #1;
        end
        check("rd_en_seen", found, 1);
        if (!found) begin cmd_empty = 1'b1; return; end
        n = cyc;
        step();
        cmd_empty = ~hold;
        junk = $urandom;
        cmd_data = {junk[23:0], op, a, b};
        step();
        cmd_data = {$urandom, $urandom, $urandom};
        rsp_full = 1'b0;
        #1;
        for (int i = 0; i < exp_lat + stall + 10; i++) begin
            if (cmd_rd_en) rd_bad++;
            if (cyc < n + exp_lat && !busy) busy_bad++;
            if (rsp_wr_en) begin wr_cyc = cyc; got = rsp_data; seen = 1'b1; break; end
            if (stall > 0 && cyc >= n + exp_lat && rsp_data !== exp) stall_bad++;
            step();
            rsp_full = (cyc >= n + exp_lat) && (cyc < n + exp_lat + stall);
            #1;
        end
        rsp_full = 1'b0;
        cmd_empty = 1'b1;
        check("rsp_written", seen, 1);
        check("rsp_latency", wr_cyc - n, exp_lat + stall);
        check("rsp_data", got, exp);
        check("busy_in_exec", busy_bad, 0);
        check("rd_en_while_busy", rd_bad, 0);
        if (stall > 0) check("stall_data_stable", stall_bad, 0);
        if (seen) m_cnt = m_cnt + 16'd1;
        step(); #1;
        check("single_write", rsp_wr_en, 0);
        check("cmd_cnt", cmd_cnt, m_cnt);
        check("err_flag", err_flag, m_err);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        int bad;
        logic [31:0] r, a, b;
        logic [7:0] op;
        int k, stall;
        logic hold;

        vecs[0] = '{8'h01, 32'hFFFF_FFFF, 32'h0000_0002, 0,  32'h0000_0001};
        vecs[1] = '{8'h05, 32'h1234_5678, 32'h9ABC_DEF0, 0,  32'h0000_0000};
        vecs[2] = '{8'h04, 32'h0001_0000, 32'h0001_0003, 0,  32'h0003_0000};
        vecs[3] = '{8'h04, 32'h0000_0003, 32'h0000_0005, 0,  32'h0003_000F};
        vecs[4] = '{8'h02, 32'h0000_0005, 32'h0000_0007, 0,  32'hFFFF_FFFE};
        vecs[5] = '{8'h03, 32'h0000_0007, 32'h0000_0006, 10, 32'h0000_002A};
        vecs[6] = '{8'h7E, 32'hDEAD_BEEF, 32'h0000_0001, 0,  32'hBAD0_007E};
        vecs[7] = '{8'h06, 32'h0000_0000, 32'h0000_0000, 0,  32'h0003_000F};
        vecs[8] = '{8'h03, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2,  32'h0000_0001};
        vecs[9] = '{8'h00, 32'h0000_0001, 32'h0000_0001, 0,  32'hBAD0_0000};

        dsa_rst = 1'b1; cmd_empty = 1'b0; rsp_full = 1'b0; cmd_data = '0;
        bad = 0;
        repeat (3) begin
            step(); #1;
            if (cmd_rd_en || rsp_wr_en) bad++;
        end
        check("strobes_in_reset", bad, 0);
        dsa_rst = 1'b0; cmd_empty = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_cmd_cnt", cmd_cnt, 0);
        check("rst_err_flag", err_flag, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rd_en", cmd_rd_en, 0);

        for (int i = 0; i < 10; i++) begin
            ref_exec(vecs[i].op, vecs[i].a, vecs[i].b, r);
            send_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].stall, 1'b1, vecs[i].exp);
        end

        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 7);
            if (k < 6)       op = 8'(k + 1);
            else if (k == 6) op = 8'($urandom_range(7, 255));
            else             op = 8'h00;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            hold = 1'($urandom_range(0, 1));
            ref_exec(op, a, b, r);
            send_cmd(op, a, b, stall, hold, r);
        end

        // Give acc a known nonzero value so the reset clearing it is observable.
        ref_exec(8'h05, 32'd0, 32'd0, r);
        send_cmd(8'h05, 32'd0, 32'd0, 0, 1'b0, r);
        ref_exec(8'h04, 32'd2, 32'd3, r);
        send_cmd(8'h04, 32'd2, 32'd3, 0, 1'b0, r);

        cmd_empty = 1'b0;
        #1;
        bad = 1;
        for (int i = 0; i < 8; i++) begin
            if (cmd_rd_en) begin bad = 0; break; end
            step(); #1;
        end
        check("mul_abort_popped", bad, 0);
        step();
        cmd_empty = 1'b1;
        cmd_data = {24'd0, 8'h03, 32'd7, 32'd6};
        step();
        repeat (15) step();
        dsa_rst = 1'b1; cmd_empty = 1'b0;
        #1;
        check("abort_rd_en", cmd_rd_en, 0);
        check("abort_wr_en", rsp_wr_en, 0);
        step();
        dsa_rst = 1'b0; cmd_empty = 1'b1;
        #1;
        m_acc = 32'd0; m_err = 1'b0; m_cnt = 16'd0;
        check("abort_busy", busy, 0);
        check("abort_cmd_cnt", cmd_cnt, 0);
        check("abort_err_flag", err_flag, 0);
        check("abort_rsp_data", rsp_data, 0);
        bad = 0;
        repeat (40) begin
            step(); #1;
            if (rsp_wr_en) bad++;
        end
        check("abort_no_write", bad, 0);
        ref_exec(8'h06, 32'd0, 32'd0, r);
        send_cmd(8'h06, 32'd0, 32'd0, 0, 1'b0, r);
        ref_exec(8'h03, 32'd7, 32'd6, r);
        send_cmd(8'h03, 32'd7, 32'd6, 0, 1'b0, r);

        force dut.cmd_cnt = 16'hFFFF;
        #1;
        release dut.cmd_cnt;
        m_cnt = 16'hFFFF;
        #1;
        check("cnt_preload", cmd_cnt, 16'hFFFF);
        ref_exec(8'h01, 32'd1, 32'd2, r);
        send_cmd(8'h01, 32'd1, 32'd2, 0, 1'b0, r);
        check("cnt_wrapped", cmd_cnt, 16'h0000);

        cmd_empty = 1'b1;
        bad = 0;
        repeat (50) begin
            step(); #1;
            if (cmd_rd_en || busy) bad++;
        end
        check("empty_idle", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsa_cmd_engine.md
DSA_CMD_ENGINE -- requirements
Module: dsa_cmd_engine

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: dsa_clk clocks every register; dsa_rst is sampled only on the rising edge of dsa_clk.
REQ-002 Port dsa_clk  input  1  block clock (one lane of the subsystem dsa_clk bus).
REQ-003 Port dsa_rst  input  1  synchronous active-high reset.
REQ-004 Port cmd_empty  input  1  command FIFO empty flag (driven by the empty_cmd lane).
REQ-005 Port cmd_rd_en  output  1  command FIFO pop; drives the rd_en_cmd lane.
REQ-006 Port cmd_data  input  96  command word; valid the cycle after cmd_rd_en=1; taken from the dsa_cmd_buffer_1 lane.
REQ-007 Port rsp_full  input  1  response FIFO full flag.
REQ-008 Port rsp_wr_en  output  1  response FIFO push; drives the wr_en_rsp lane.
REQ-009 Port rsp_data  output  32  response word; valid when rsp_wr_en=1.
REQ-010 Port busy  output  1  high in any state other than IDLE.
REQ-011 Port cmd_cnt  output  16  count of completed responses; wraps from 0xFFFF to 0x0000.
REQ-012 Port err_flag  output  1  sticky; set when an illegal opcode is executed.

Function
REQ-013 Command fields SHALL be: opcode = cmd_data[71:64]; A = cmd_data[63:32]; B = cmd_data[31:0]; cmd_data[95:72] is ignored.
REQ-014 FSM states SHALL be IDLE, LOAD, EXEC, RESP.
- IDLE -> LOAD when cmd_empty=0; cmd_rd_en=1 for exactly that one cycle.
- LOAD: latch opcode/A/B from cmd_data -> EXEC.
- EXEC -> RESP.
- RESP -> IDLE.
REQ-015 cmd_rd_en SHALL be asserted only in IDLE, and only while cmd_empty=0; it is never asserted in any other state.
REQ-016 Opcodes and results (all arithmetic modulo 2^32, results unsigned):
- 0x01 ADD: A+B.
- 0x02 SUB: A-B.
- 0x03 MUL: low 32 bits of A*B.
- 0x04 MAC: acc <= acc + low32(A*B); result = new acc.
- 0x05 CLR: acc <= 0; result = 0.
- 0x06 RDACC: result = acc.
REQ-017 Any other opcode: result = {24'hBAD000, opcode}; err_flag set; acc unchanged.
REQ-018 ADD, SUB, CLR, RDACC and illegal opcodes SHALL spend exactly 1 cycle in EXEC.
REQ-019 MUL and MAC SHALL spend exactly 32 cycles in EXEC, using an iterative shift-add over the 32 bits of B with a 5-bit step counter; no combinational 32x32 multiplier is permitted.
REQ-020 Latency, with cmd_rd_en at cycle N and rsp_full=0:
- single-cycle ops: rsp_wr_en=1 at N+3.
- MUL/MAC: rsp_wr_en=1 at N+34.
REQ-021 In RESP, rsp_wr_en SHALL equal ~rsp_full; while rsp_full=1 the FSM holds in RESP and keeps rsp_data stable.
REQ-022 On the cycle rsp_wr_en=1, the FSM SHALL move to IDLE and cmd_cnt SHALL increment; at most one response is written per command.
REQ-023 Minimum command spacing SHALL be 4 cycles: the next cmd_rd_en can occur no earlier than the cycle after the write.
REQ-024 The acc update for MAC/CLR SHALL occur on the EXEC->RESP transition, independent of back-pressure in RESP.
REQ-025 rsp_data SHALL be registered and SHALL change only on EXEC->RESP.
REQ-026 cmd_data SHALL be ignored in every cycle except LOAD.

Reset
REQ-027 When dsa_rst=1 at a clock edge, the following SHALL hold: state=IDLE, cmd_rd_en=0, rsp_wr_en=0, rsp_data=0, busy=0, cmd_cnt=0, err_flag=0, acc=0, step counter=0.
REQ-028 Reset asserted mid-operation (any state, including EXEC mid-MUL or RESP stalled) SHALL abort the command with no response write; a command already popped is lost.
REQ-029 While dsa_rst=1, cmd_rd_en and rsp_wr_en SHALL be 0 regardless of FIFO flags.

Verification
REQ-030 ADD: cmd opcode=0x01, A=0xFFFFFFFF, B=0x00000002, rsp_full=0 -> rsp_data=0x00000001 with rsp_wr_en at N+3; cmd_cnt=1.
REQ-031 MAC pair: CLR, then MAC A=0x00010000 B=0x00010003, then MAC A=3 B=5 -> responses 0, 0x00030000 (at N+34), 0x0003000F; busy high throughout EXEC.
REQ-032 Back-pressure: MUL A=7 B=6 with rsp_full=1 for 10 cycles after RESP entry -> no write while full, rsp_data stable at 0x0000002A, exactly one write the cycle rsp_full drops.
REQ-033 Illegal opcode 0x7E -> rsp_data=0xBAD0007E, err_flag=1 and stays 1 through following legal commands; acc unchanged.
REQ-034 Reset mid-MUL (EXEC cycle 15): dsa_rst=1 for one cycle -> no rsp_wr_en, cmd_cnt=0, acc=0, state IDLE; next command executes correctly.
REQ-035 Wrap and empty: preload cmd_cnt to 0xFFFF via 65535 ADDs (or force), one more command -> cmd_cnt=0x0000; with cmd_empty=1 held, cmd_rd_en remains 0 indefinitely.
